logic_op_scheduler: RTL
=======================

# logic_op_scheduler

Shares a single 1-bit logic-gate unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) between two requesters and applies the selected operation bit-serially across WIDTH-bit operands. Requests arrive on two valid/ready ports and are granted round-robin. The granted operands are streamed LSB-first through the gate unit, one bit per cycle. The assembled result is returned on one valid/ready response port, tagged with the requester ID.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_op  input  3  operation code for requester 0
- req0_a, req0_b  input  WIDTH  operands for requester 0
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  WIDTH  result word
- rsp_id  output  1  requester that issued the result
- busy  output  1  high in RUN or DONE

## Operation
- Op encoding:
  - 0 AND, 1 OR, 2 NOT (~a; b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
  - 7 is reserved and yields all-zero rsp_data.
- All seven functions are computed from the current bit pair each RUN cycle. A mux selects one by the latched op.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If either valid is high, the arbiter grants one requester.
  - Only the granted requester sees ready=1. Ready is combinational from state, valid, and the priority pointer.
  - On a handshake: latch op, a, b and id; clear bit index to 0; go to RUN.
- Arbitration:
  - A 1-bit priority pointer, reset to requester 0.
  - If only one requester is valid, it is granted regardless of the pointer.
  - If both are valid, the pointer's requester is granted.
  - After every grant, the pointer moves to the non-granted requester.
- RUN:
  - Each cycle, apply a[idx] and b[idx] to the gate unit and write the selected output into result[idx]. Then idx increments.
  - After the bit with idx = WIDTH-1 is written, go to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - On rsp_valid && rsp_ready, go to IDLE.
- Requester inputs that change after acceptance have no effect. Valid may be held high across a busy period without penalty.
- Reset values: state IDLE, pointer 0, idx 0, result 0, rsp_valid 0, rsp_data 0, rsp_id 0, busy 0. req*_ready is 0 during reset.
- Reset mid-RUN or mid-DONE aborts the operation. The result is discarded, no response is issued, and all state returns to reset values on the next edge.
- rsp_ready held low in DONE stalls indefinitely. No new request is accepted while stalled.

## Timing
- Accept edge E0 (cycle with valid && ready):
  - RUN occupies cycles E0+1 .. E0+WIDTH.
  - rsp_valid is first high in cycle E0+WIDTH+1.
- The response handshake in cycle R returns the FSM to IDLE in R+1. The earliest next accept is in cycle R+1.
- Minimum request-to-request spacing is WIDTH+2 cycles (WIDTH=8 gives 10 cycles).
- WIDTH=1 is legal: RUN lasts exactly 1 cycle.
- At most one of req0_ready and req1_ready is high in any cycle. Neither is high outside IDLE.
- rsp_valid, once high, stays high until the handshake. rsp_data does not change while rsp_valid=1.

## Test plan
- WIDTH=8, only req0, op=5, a=0xA5, b=0x0F, rsp_ready=1 -> rsp_data=0xAA and rsp_id=0, with rsp_valid first high 9 cycles after the accept cycle; busy high for exactly 9 cycles.
- Both valid after reset, req0 op=0 (a=0xF0, b=0x3C), req1 op=3 (a=0xFF, b=0xFF), both held valid:
  - 0x30 (id 0), then 0x00 (id 1), then 0x30 (id 0); strictly alternating.
  - Accepts spaced 10 cycles apart.
- req1 op=2, a=0x5A, b=0xFF -> 0xA5; b has no influence.
- Backpressure:
  - rsp_ready=0 for 20 cycles after rsp_valid rises -> rsp_valid, data and id stable throughout.
  - No ready asserted to either requester during the stall.
  - The handshake completes on the first cycle rsp_ready=1.
- rst=1 pulsed in the 4th RUN cycle -> next cycle shows all outputs at reset values; no response for the aborted request; the pointer is back to requester 0.
- op=7 with a=0xFF, b=0xFF -> rsp_data=0x00; op=6 with a=0x0F, b=0x3C -> 0xCC.

Source files
------------

// File: rtl/logic_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : logic_op_scheduler
//  Description : Two-requester round-robin front end for one shared 1-bit
//                logic-gate unit. The granted request's operands are streamed
//                LSB-first through the gate, one bit per cycle, and the
//                assembled word is returned on a tagged valid/ready response.
//  Revision    : 1.0  initial release
// ============================================================================
module logic_op_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,

    output logic             busy
);

    // Bit index must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int              IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

    // Operation codes
    localparam logic [2:0] C_OP_AND  = 3'd0;
    localparam logic [2:0] C_OP_OR   = 3'd1;
    localparam logic [2:0] C_OP_NOT  = 3'd2;
    localparam logic [2:0] C_OP_NAND = 3'd3;
    localparam logic [2:0] C_OP_NOR  = 3'd4;
    localparam logic [2:0] C_OP_XOR  = 3'd5;
    localparam logic [2:0] C_OP_XNOR = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic              ptr_q,    ptr_d;     // requester favoured on a tie
    logic [IDX_W-1:0]  idx_q,    idx_d;     // bit currently being processed
    logic [2:0]        op_q,     op_d;
    logic [WIDTH-1:0]  a_q,      a_d;
    logic [WIDTH-1:0]  b_q,      b_d;
    logic              id_q,     id_d;
    logic [WIDTH-1:0]  result_q, result_d;

    logic              w_grant1;            // arbiter picks requester 1
    logic              w_can_accept;        // FSM able to take a request now
    logic              w_accept;            // a handshake happens this cycle
    logic              w_a_bit;
    logic              w_b_bit;
    logic              w_gate_bit;

    // Arbitration: a lone requester always wins; on a tie the pointer decides.
    always_comb begin
        w_grant1     = req1_valid && (!req0_valid || ptr_q);
        w_can_accept = (state_q == S_IDLE) && !rst;
        req0_ready   = w_can_accept && req0_valid && !w_grant1;
        req1_ready   = w_can_accept && w_grant1;
        w_accept     = req0_ready || req1_ready;
    end

    // Shared gate unit: every function evaluated on the current bit pair,
    // the latched op selects which one is written back.
    always_comb begin
        w_a_bit    = a_q[idx_q];
        w_b_bit    = b_q[idx_q];
        w_gate_bit = 1'b0;
        case (op_q)
            C_OP_AND:  w_gate_bit =   w_a_bit & w_b_bit;
            C_OP_OR:   w_gate_bit =   w_a_bit | w_b_bit;
            C_OP_NOT:  w_gate_bit =  ~w_a_bit;
            C_OP_NAND: w_gate_bit = ~(w_a_bit & w_b_bit);
            C_OP_NOR:  w_gate_bit = ~(w_a_bit | w_b_bit);
            C_OP_XOR:  w_gate_bit =   w_a_bit ^ w_b_bit;
            C_OP_XNOR: w_gate_bit = ~(w_a_bit ^ w_b_bit);
            default:   w_gate_bit = 1'b0;   // reserved op gives zeros
        endcase
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequencer and datapath.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    id_d     = w_grant1;
                    op_d     = w_grant1 ? req1_op : req0_op;
                    a_d      = w_grant1 ? req1_a  : req0_a;
                    b_d      = w_grant1 ? req1_b  : req0_b;
                    idx_d    = '0;
                    result_d = '0;
                    // Favour the other requester next time.
                    ptr_d    = ~w_grant1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[idx_q] = w_gate_bit;
                if (idx_q == C_LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + C_IDX_ONE;
                end
            end
            S_DONE: begin
                // Result and tag held until the consumer takes them.
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset also aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b0;
            idx_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            result_q <= result_d;
        end
    end

    // Response and status outputs derived directly from registered state.
    always_comb begin
        rsp_valid = (state_q == S_DONE);
        rsp_data  = result_q;
        rsp_id    = id_q;
        busy      = (state_q != S_IDLE);
    end

endmodule
`default_nettype wire
